// File: rtl/mips_data_mem.sv
// Data-memory responder for the MIPS CPU: byte-lane RAM with registered reads,
// plus an MMIO window holding the LED register, a cycle counter and a store counter.
module mips_data_mem #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [15:0] MMIO_TAG   = 16'hFFFF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [3:0]           mem_write_en,
    input  logic                 mem_read_en,
    input  logic [31:0]          mem_addr,
    input  logic [31:0]          mem_write_data,
    output logic [31:0]          mem_read_data,
    output logic [7:0]           leds,
    output logic                 bus_error
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        REGION_RAM,
        REGION_MMIO,
        REGION_NONE
    } region_t;

    logic [31:0]           ram [DEPTH];
    logic [31:0]           cycles;
    logic [31:0]           stores;
    region_t               region;
    logic [ADDR_WIDTH-1:0] idx;
    logic [13:0]           mmio_word;
    logic                  any_we;
    logic [31:0]           rd_word;
    logic                  ram_wr;
    logic                  led_wr;
    logic                  cycles_clr;

    assign idx       = mem_addr[ADDR_WIDTH+1:2];
    assign mmio_word = mem_addr[15:2];
    assign any_we    = |mem_write_en;

    always_comb begin
        region = REGION_NONE;
        if (mem_addr[31:ADDR_WIDTH+2] == '0)
            region = REGION_RAM;
        else if (mem_addr[31:16] == MMIO_TAG)
            region = REGION_MMIO;
    end

    // Read data is taken before this edge's updates, giving read-old-data semantics.
    always_comb begin
        rd_word = '0;
        unique case (region)
            REGION_RAM:  rd_word = ram[idx];
            REGION_MMIO: begin
                if (mmio_word == 14'd0)
                    rd_word = {24'b0, leds};
                else if (mmio_word == 14'd1)
                    rd_word = cycles;
                else if (mmio_word == 14'd2)
                    rd_word = stores;
            end
            default:     rd_word = 32'hDEADBEEF;
        endcase
    end

    assign ram_wr     = en && any_we && (region == REGION_RAM);
    assign led_wr     = en && mem_write_en[0] && (region == REGION_MMIO) && (mmio_word == 14'd0);
    assign cycles_clr = en && any_we && (region == REGION_MMIO) && (mmio_word == 14'd1);

    always_ff @(posedge clk) begin
        if (ram_wr) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (mem_write_en[i])
                    ram[idx][8*i +: 8] <= mem_write_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_read_data <= '0;
            leds          <= '0;
            cycles        <= '0;
            stores        <= '0;
            bus_error     <= 1'b0;
        end else if (en) begin
            if (mem_read_en)
                mem_read_data <= rd_word;
            if (led_wr)
                leds <= mem_write_data[7:0];
            if (cycles_clr)
                cycles <= '0;
            else
                cycles <= cycles + 32'd1;
            if (ram_wr)
                stores <= stores + 32'd1;
            if ((region == REGION_NONE) && (mem_read_en || any_we))
                bus_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mips_data_mem.sv
// Randomized and directed checks of mips_data_mem against a behavioural model.
module tb_mips_data_mem;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  mem_write_en = '0;
    logic        mem_read_en = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_write_data = '0;
    logic [31:0] mem_read_data;
    logic [7:0]  leds;
    logic        bus_error;

    int unsigned total = 0;
    int unsigned bad = 0;

    // behavioural model state
    logic [31:0] m_ram [1024];
    logic [31:0] m_rd, m_cyc, m_st;
    logic [7:0]  m_leds;
    logic        m_err;
    logic [31:0] saved;

    mips_data_mem #(.ADDR_WIDTH(10), .MMIO_TAG(16'hFFFF)) dut (
        .clk(clk), .rst(rst), .en(en),
        .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .leds(leds), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_rd = 0; m_cyc = 0; m_st = 0; m_leds = 0; m_err = 0;
    endtask

    // One clock: drive at negedge, update the model, check at the next negedge.
    task automatic cyc(input bit e, input logic [3:0] we, input bit re,
                       input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rv, w;
        bit is_ram, is_mmio, any;
        int unsigned word, off;
        en = e; mem_write_en = we; mem_read_en = re; mem_addr = a; mem_write_data = d;
        if (e) begin
            is_ram  = a < 32'd4096;
            is_mmio = (a / 32'h10000) == 32'hFFFF;
            any     = we != 4'b0;
            word    = (a % 4096) / 4;
            off     = (a % 32'h10000) / 4;
            if (is_ram)            rv = m_ram[word];
            else if (is_mmio)      rv = (off == 0) ? {24'b0, m_leds} :
                                        (off == 1) ? m_cyc :
                                        (off == 2) ? m_st : 32'd0;
            else                   rv = 32'hDEADBEEF;
            if (re) m_rd = rv;
            if (!is_ram && !is_mmio && (re || any)) m_err = 1;
            if (is_ram && any) begin
                w = m_ram[word];
                for (int i = 0; i < 4; i++)
                    if (we[i]) w = (w & ~(32'hFF << (8*i))) | (d & (32'hFF << (8*i)));
                m_ram[word] = w;
                m_st = m_st + 1;
            end
            if (is_mmio && off == 0 && we[0]) m_leds = d[7:0];
            if (is_mmio && off == 1 && any) m_cyc = 0;
            else                            m_cyc = m_cyc + 1;
        end
        @(posedge clk);
        @(negedge clk);
        check32("rdata", mem_read_data, m_rd);
        check32("leds", {24'b0, leds}, {24'b0, m_leds});
        check32("bus_error", {31'b0, bus_error}, {31'b0, m_err});
    endtask

    initial begin
        #2 rst = 1'b1;
        #1;
        check32("rst_rdata", mem_read_data, 32'h0);
        check32("rst_leds", {24'b0, leds}, 32'h0);
        check32("rst_err", {31'b0, bus_error}, 32'h0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        model_reset();

        // word write then read; store count
        cyc(1, 4'hF, 0, 32'h10, 32'h11223344);
        cyc(1, 4'h0, 1, 32'h10, 32'h0);
        check32("word_rd", mem_read_data, 32'h11223344);
        cyc(1, 4'h0, 1, 32'hFFFF0008, 32'h0);
        check32("stores_1", mem_read_data, 32'h1);

        // byte-lane merge
        cyc(1, 4'b0100, 0, 32'h10, 32'hAAAAAAAA);
        cyc(1, 4'h0, 1, 32'h10, 32'h0);
        check32("lane_merge", mem_read_data, 32'h11AA3344);

        // same-cycle read and write returns old data
        cyc(1, 4'hF, 0, 32'h20, 32'h5);
        cyc(1, 4'hF, 1, 32'h20, 32'h9);
        check32("rw_old", mem_read_data, 32'h5);
        cyc(1, 4'h0, 1, 32'h20, 32'h0);
        check32("rw_new", mem_read_data, 32'h9);

        // enable gating
        cyc(1, 4'hF, 0, 32'h30, 32'h3);
        cyc(1, 4'h0, 1, 32'hFFFF0004, 32'h0);
        saved = mem_read_data;
        cyc(0, 4'hF, 1, 32'h30, 32'h7);
        check32("en_hold", mem_read_data, saved);
        cyc(1, 4'h0, 1, 32'hFFFF0004, 32'h0);
        check32("en_cycles", mem_read_data, saved + 32'd1);
        cyc(1, 4'h0, 1, 32'h30, 32'h0);
        check32("en_ram", mem_read_data, 32'h3);

        // MMIO
        cyc(1, 4'b0001, 0, 32'hFFFF0000, 32'hA5);
        check32("leds_a5", {24'b0, leds}, 32'hA5);
        cyc(1, 4'hF, 0, 32'hFFFF0004, 32'h123);
        cyc(1, 4'h0, 1, 32'hFFFF0004, 32'h0);
        check32("cyc_clr", mem_read_data, 32'h0);
        cyc(1, 4'h0, 1, 32'hFFFF000C, 32'h0);
        check32("mmio_other", mem_read_data, 32'h0);

        // cycle counter wrap
        force dut.cycles = 32'hFFFFFFFF;
        #1 release dut.cycles;
        m_cyc = 32'hFFFFFFFF;
        cyc(1, 4'h0, 1, 32'hFFFF0004, 32'h0);
        check32("cyc_max", mem_read_data, 32'hFFFFFFFF);
        cyc(1, 4'h0, 1, 32'hFFFF0004, 32'h0);
        check32("cyc_wrap", mem_read_data, 32'h0);

        // unmapped access, sticky error
        cyc(1, 4'h0, 1, 32'h80000000, 32'h0);
        check32("unmap_rd", mem_read_data, 32'hDEADBEEF);
        check32("unmap_err", {31'b0, bus_error}, 32'h1);
        cyc(1, 4'hF, 0, 32'h10, 32'h55667788);
        cyc(1, 4'h0, 1, 32'h10, 32'h0);
        check32("err_sticky", {31'b0, bus_error}, 32'h1);

        // asynchronous reset mid-read
        en = 1; mem_read_en = 1; mem_addr = 32'h10;
        #2 rst = 1'b1;
        #1;
        check32("arst_rdata", mem_read_data, 32'h0);
        check32("arst_leds", {24'b0, leds}, 32'h0);
        check32("arst_err", {31'b0, bus_error}, 32'h0);
        @(negedge clk); @(negedge clk);
        check32("arst_hold", mem_read_data, 32'h0);
        rst = 1'b0;
        model_reset();

        // initialise the low words, then random traffic
        for (int i = 0; i < 16; i++)
            cyc(1, 4'hF, 0, i * 4, $urandom);
        for (int n = 0; n < 500; n++) begin
            int unsigned r;
            logic [31:0] a;
            logic [3:0]  we;
            r = $urandom_range(0, 19);
            if (r < 14)      a = $urandom_range(0, 15) * 4;
            else if (r < 19) a = 32'hFFFF0000 + $urandom_range(0, 3) * 4;
            else             a = 32'h00010000 + $urandom_range(0, 255) * 4;
            we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            cyc($urandom_range(0, 7) != 0, we, $urandom_range(0, 1) == 1, a, $urandom);
        end
        // final check of counters through the bus
        cyc(1, 4'h0, 1, 32'hFFFF0008, 32'h0);
        cyc(1, 4'h0, 1, 32'hFFFF0004, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
